adsb_demod: RTL and testbench

- PPM demodulator directly downstream of the ADS-B pulse detector.
- On each detector trigger it validates the 8 us preamble from sliced data, then integrates aligned log magnitude over each half-bit to make bit decisions.
- It assembles a 56- or 112-bit Mode S frame and hands it out on a valid/ready port.
- It pulses trigger_clr back to the detector when done, so the detector re-arms.

---
 rtl/adsb_demod.sv | 173 +++++++++++++++++
 tb/tb_adsb_demod.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsb_demod.sv
// ADS-B PPM demodulator: preamble validation, half-bit energy compare,
// Mode S frame assembly (56/112 bits) and a single-entry output buffer.
//
// state  | meaning
// IDLE   | waiting for a detector trigger
// PRE    | checking sliced preamble at each chip centre (chips 1..15)
// DATA   | integrating half-bits and shifting decided bits into the frame
module adsb_demod #(
  parameter int WIDTH    = 10,
  parameter int CHIP_LEN = 10,
  parameter int LEAD     = 6
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_ena,
  input  logic               i_trigger,
  input  logic               i_retrigger,
  input  logic               i_slice_data,
  input  logic [WIDTH-1:0]   i_logmag,
  output logic               o_trigger_clr,
  output logic               o_busy,
  output logic               o_preamble_err,
  output logic               o_overflow,
  output logic               o_frame_valid,
  input  logic               i_frame_ready,
  output logic               o_frame_long,
  output logic [111:0]       o_frame_data
);

  localparam int AW = WIDTH + 4;
  localparam logic [7:0] CHIP0   = 8'(LEAD / CHIP_LEN);
  localparam logic [7:0] PHASE0  = 8'(LEAD % CHIP_LEN);
  localparam logic [7:0] PH_MID  = 8'(CHIP_LEN / 2);
  localparam logic [7:0] PH_LAST = 8'(CHIP_LEN - 1);
  // Preamble pulses sit in chips 2, 7 and 9 (chip 0 is P1 itself, not sampled).
  localparam logic [15:0] PRE_ONES = 16'h0284;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2} state_t;

  state_t        r_state, w_state_nx;
  logic [11:0]   r_offset;
  logic [7:0]    r_chip, r_phase, w_chip, w_phase;
  logic [AW-1:0] r_acc_a, r_acc_b, w_sum_b;
  logic [6:0]    r_nbits;
  logic          r_long;
  logic [111:0]  r_shift, w_shift_nx;
  logic          w_accept, w_restart, w_sample, w_pre_bad, w_pre_done;
  logic          w_in_data, w_half_b, w_decide, w_bit, w_done;
  logic          w_busy, w_clr_req;
  logic          r_trigger_clr, r_preamble_err, r_overflow, r_frame_valid, r_frame_long;
  logic [111:0]  r_frame_data;

  // chip/phase of the sample presented on the current ena cycle
  assign w_phase = (r_phase == PH_LAST) ? 8'd0 : r_phase + 8'd1;
  assign w_chip  = (r_phase == PH_LAST) ? r_chip + 8'd1 : r_chip;

  assign w_accept   = (r_state == S_IDLE) && i_ena && i_trigger;
  assign w_restart  = (r_state == S_DATA) && i_ena && i_retrigger;
  assign w_sample   = (r_state == S_PRE) && i_ena && (w_phase == PH_MID) && (w_chip >= 8'd1);
  assign w_pre_bad  = w_sample && (i_slice_data != PRE_ONES[w_chip[3:0]]);
  assign w_pre_done = w_sample && !w_pre_bad && (w_chip == 8'd15);

  // even chips from 16 on are the first half of a bit, odd chips the second
  assign w_in_data  = (r_state == S_DATA) && i_ena && !i_retrigger && (w_chip >= 8'd16);
  assign w_half_b   = w_chip[0];
  assign w_sum_b    = r_acc_b + AW'(i_logmag);
  assign w_bit      = r_acc_a > w_sum_b;
  assign w_decide   = w_in_data && w_half_b && (w_phase == PH_LAST);
  assign w_shift_nx = {r_shift[110:0], w_bit};
  assign w_done     = w_decide && (r_nbits == (r_long ? 7'd111 : 7'd55));

  // state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nx;
  end

  // next-state logic; a retrigger wins over completion in the same cycle
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nx = S_PRE;
      S_PRE: begin
        if (w_pre_bad)       w_state_nx = S_IDLE;
        else if (w_pre_done) w_state_nx = S_DATA;
      end
      S_DATA: begin
        if (w_restart)   w_state_nx = S_PRE;
        else if (w_done) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // state-derived outputs and requests for the registered pulses
  always_comb begin
    w_busy    = (r_state == S_PRE) || (r_state == S_DATA);
    w_clr_req = w_done || w_pre_bad;
  end

  // offset/chip/phase counters, half-bit accumulators and bit shifter
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_offset <= '0;
      r_chip   <= '0;
      r_phase  <= '0;
      r_acc_a  <= '0;
      r_acc_b  <= '0;
      r_nbits  <= '0;
      r_long   <= 1'b0;
      r_shift  <= '0;
    end else if (w_accept || w_restart) begin
      r_offset <= '0;
      r_chip   <= CHIP0;
      r_phase  <= PHASE0;
      r_acc_a  <= '0;
      r_acc_b  <= '0;
      r_nbits  <= '0;
      r_long   <= 1'b0;
      r_shift  <= '0;
    end else if (i_ena && (r_state != S_IDLE)) begin
      r_offset <= r_offset + 12'd1;
      r_chip   <= w_chip;
      r_phase  <= w_phase;
      if (w_in_data) begin
        if (!w_half_b) r_acc_a <= ((w_phase == 8'd0) ? '0 : r_acc_a) + AW'(i_logmag);
        else           r_acc_b <= ((w_phase == 8'd0) ? '0 : r_acc_b) + AW'(i_logmag);
      end
      if (w_decide) begin
        r_shift <= w_shift_nx;
        r_nbits <= r_nbits + 7'd1;
        // DF >= 16 exactly when the first received bit is 1
        if (r_nbits == 7'd4) r_long <= w_shift_nx[4];
      end
    end
  end

  // output buffer, handshake and one-clock status pulses
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_trigger_clr  <= 1'b0;
      r_preamble_err <= 1'b0;
      r_overflow     <= 1'b0;
      r_frame_valid  <= 1'b0;
      r_frame_long   <= 1'b0;
      r_frame_data   <= '0;
    end else begin
      r_trigger_clr  <= w_clr_req;
      r_preamble_err <= w_pre_bad;
      r_overflow     <= 1'b0;
      if (w_done) begin
        if (!r_frame_valid || i_frame_ready) begin
          r_frame_valid <= 1'b1;
          r_frame_long  <= r_long;
          r_frame_data  <= r_long ? w_shift_nx : {w_shift_nx[55:0], 56'd0};
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_frame_valid && i_frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign o_trigger_clr  = r_trigger_clr;
  assign o_busy         = w_busy;
  assign o_preamble_err = r_preamble_err;
  assign o_overflow     = r_overflow;
  assign o_frame_valid  = r_frame_valid;
  assign o_frame_long   = r_frame_long;
  assign o_frame_data   = r_frame_data;

endmodule

// File: tb/tb_adsb_demod.sv
// Bench for adsb_demod: synthesizes PPM waveforms from frame bit patterns and
// checks recovered frames, timing and status pulses against a frame-level model.
module tb_adsb_demod;
  localparam int WIDTH    = 10;
  localparam int CHIP_LEN = 10;
  localparam int LEAD     = 6;
  localparam int AMP      = 400;
  localparam int NOISE    = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0, trigger = 1'b0, retrigger = 1'b0, slice = 1'b0, frame_ready = 1'b0;
  logic [WIDTH-1:0] logmag = '0;
  logic trigger_clr, busy, preamble_err, overflow, frame_valid, frame_long;
  logic [111:0] frame_data;

  int n_cmp = 0, n_bad = 0;
  int ecnt = 0;
  int n_clr = 0, n_perr = 0, n_ovf = 0, n_vrise = 0, n_unstable = 0;
  int clr_e = -1, perr_e = -1, ovf_e = -1, vrise_e = -1;
  logic prev_valid = 1'b0, prev_long = 1'b0;
  logic [111:0] prev_data = '0;
  int trig_e = 0, done_e = 0;

  always #5 clk = ~clk;

  adsb_demod #(.WIDTH(WIDTH), .CHIP_LEN(CHIP_LEN), .LEAD(LEAD)) u_dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_ena          (ena),
    .i_trigger      (trigger),
    .i_retrigger    (retrigger),
    .i_slice_data   (slice),
    .i_logmag       (logmag),
    .o_trigger_clr  (trigger_clr),
    .o_busy         (busy),
    .o_preamble_err (preamble_err),
    .o_overflow     (overflow),
    .o_frame_valid  (frame_valid),
    .i_frame_ready  (frame_ready),
    .o_frame_long   (frame_long),
    .o_frame_data   (frame_data)
  );

  // edge counter and event recorder, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    ecnt <= ecnt + 1;
    if (trigger_clr)  begin n_clr  <= n_clr + 1;  clr_e  <= ecnt + 1; end
    if (preamble_err) begin n_perr <= n_perr + 1; perr_e <= ecnt + 1; end
    if (overflow)     begin n_ovf  <= n_ovf + 1;  ovf_e  <= ecnt + 1; end
    if (frame_valid && !prev_valid) begin n_vrise <= n_vrise + 1; vrise_e <= ecnt + 1; end
    if (prev_valid && frame_valid && !frame_ready &&
        (frame_data != prev_data || frame_long != prev_long))
      n_unstable <= n_unstable + 1;
    prev_valid <= frame_valid;
    prev_data  <= frame_data;
    prev_long  <= frame_long;
  end

  task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_long(input logic [111:0] bits);
    return bits[111:107] >= 5'd16;
  endfunction

  function automatic logic [111:0] exp_data(input logic [111:0] bits);
    if (is_long(bits)) return bits;
    return {bits[111:56], 56'd0};
  endfunction

  // offset of the ena cycle closing the last half-chip
  function automatic int done_off(input logic [111:0] bits);
    int nb;
    nb = is_long(bits) ? 112 : 56;
    return CHIP_LEN * (17 + 2 * (nb - 1)) - LEAD + CHIP_LEN - 1;
  endfunction

  // ideal PPM waveform for offset o: preamble pulses, then bit k high in
  // its first half when 1 and in its second half when 0
  function automatic void stim(input int o, input logic [111:0] bits, input bit tie,
                               input int bad_off, output logic s, output logic [WIDTH-1:0] m);
    int c, k, nb, lvl;
    bit hi, is_bit, one;
    nb = is_long(bits) ? 112 : 56;
    c = (o + LEAD) / CHIP_LEN;
    k = (c - 16) / 2;
    is_bit = (c >= 16) && (k < nb);
    if (is_bit) one = bits[111 - k];
    else        one = 1'b0;
    if (c < 16) hi = (c == 0) || (c == 2) || (c == 7) || (c == 9);
    else        hi = is_bit && (one == (((c - 16) % 2) == 0));
    s = hi || (o == bad_off);
    if (tie && is_bit && !one) lvl = NOISE;
    else lvl = (hi ? AMP : NOISE) + int'($urandom_range(0, 30));
    m = WIDTH'(lvl);
  endfunction

  function automatic logic [111:0] rand_frame(input int kind);
    logic [111:0] f;
    logic [31:0] r;
    r = $urandom; f[111:80] = r;
    r = $urandom; f[79:48] = r;
    r = $urandom; f[47:16] = r;
    r = $urandom; f[15:0] = r[15:0];
    if (kind == 0) f[111] = 1'b0;
    else if (kind == 1) f[111] = 1'b1;
    if (!f[111]) f[55:0] = '0;
    return f;
  endfunction

  // drive one frame from offset 0 to stop_off; ena asserted every duty-th clock
  task automatic play(input logic [111:0] bits, input int duty, input int stop_off,
                      input int bad_off, input bit retrig, input bit tie, input bit rdy_done);
    int o, ph;
    logic s;
    logic [WIDTH-1:0] m;
    o = 0; ph = 0; trig_e = -1;
    while (o <= stop_off) begin
      @(negedge clk);
      ena = ((ph % duty) == duty - 1);
      ph++;
      trigger   = (o == 0) && !retrig;
      retrigger = (o == 0) && retrig && ena;
      stim(o, bits, tie, bad_off, s, m);
      slice  = s;
      logmag = m;
      frame_ready = rdy_done && ena && (o == stop_off);
      if (trig_e < 0) trig_e = ecnt;
      if (ena && o == stop_off) done_e = ecnt + 1;
      if (ena) o++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ena = 1'b0; trigger = 1'b0; retrigger = 1'b0; slice = 1'b0;
      logmag = '0; frame_ready = 1'b0;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk); frame_ready = 1'b1;
    @(negedge clk); frame_ready = 1'b0;
    check({tag, "_drop"}, 112'(frame_valid), 112'(0));
  endtask

  task automatic expect_frame(input string tag, input logic [111:0] bits, input int vr0);
    check({tag, "_valid"}, 112'(frame_valid), 112'(1));
    check({tag, "_long"},  112'(frame_long), 112'(is_long(bits)));
    check({tag, "_data"},  frame_data, exp_data(bits));
    check({tag, "_when"},  112'(vrise_e), 112'(done_e));
    check({tag, "_clr"},   112'(clr_e), 112'(done_e));
    check({tag, "_nrise"}, 112'(n_vrise), 112'(vr0 + 1));
    check({tag, "_busy"},  112'(busy), 112'(0));
  endtask

  initial begin
    logic [111:0] fa, fb, f1, f2, f3;
    int v0, c0, p0, o0;

    fa = {56'h5D4840D6202CC3, 56'd0};
    fb = 112'h8D4840D6202CC371C32CE0576098;

    idle(3);
    check("rst_valid", 112'(frame_valid), 112'(0));
    check("rst_busy",  112'(busy), 112'(0));
    check("rst_clr",   112'(trigger_clr), 112'(0));
    check("rst_err",   112'(preamble_err), 112'(0));
    check("rst_ovf",   112'(overflow), 112'(0));
    check("rst_long",  112'(frame_long), 112'(0));
    check("rst_data",  frame_data, 112'(0));
    rst_n = 1'b1;
    idle(2);

    // clean short frame
    v0 = n_vrise;
    play(fa, 1, done_off(fa), -1, 0, 0, 0);
    idle(3);
    expect_frame("short", fa, v0);
    check("short_lat", 112'(vrise_e - trig_e), 112'(1274));
    consume("short");

    // clean long frame
    v0 = n_vrise;
    play(fb, 1, done_off(fb), -1, 0, 0, 0);
    idle(3);
    expect_frame("long", fb, v0);
    check("long_lat", 112'(vrise_e - trig_e), 112'(2394));
    consume("long");

    // spurious pulse in chip 5, then in chip 15
    v0 = n_vrise; p0 = n_perr; c0 = n_clr;
    play(fa, 1, 49, 49, 0, 0, 0);
    idle(3);
    check("pre5_err_n", 112'(n_perr), 112'(p0 + 1));
    check("pre5_err_t", 112'(perr_e), 112'(done_e));
    check("pre5_clr_t", 112'(clr_e), 112'(done_e));
    check("pre5_lat",   112'(perr_e - trig_e), 112'(50));
    check("pre5_busy",  112'(busy), 112'(0));
    play(fa, 1, 149, 149, 0, 0, 0);
    idle(3);
    check("pre15_err_t", 112'(perr_e), 112'(done_e));
    check("pre_clr_n",   112'(n_clr), 112'(c0 + 2));
    check("pre_noframe", 112'(n_vrise), 112'(v0));

    // back-to-back frames with the consumer stalled
    f1 = rand_frame(0); f2 = rand_frame(2); f3 = rand_frame(0);
    v0 = n_vrise; o0 = n_ovf;
    play(f1, 1, done_off(f1), -1, 0, 0, 0);
    idle(2);
    expect_frame("ovf_first", f1, v0);
    play(f2, 1, done_off(f2), -1, 0, 0, 0);
    idle(2);
    check("ovf_n",     112'(n_ovf), 112'(o0 + 1));
    check("ovf_t",     112'(ovf_e), 112'(done_e));
    check("ovf_clr_t", 112'(clr_e), 112'(done_e));
    check("ovf_held",  frame_data, exp_data(f1));
    check("ovf_valid", 112'(frame_valid), 112'(1));
    // completion coinciding with acceptance replaces the frame
    play(f3, 1, done_off(f3), -1, 0, 1, 1);
    idle(2);
    check("swap_data",  frame_data, exp_data(f3));
    check("swap_valid", 112'(frame_valid), 112'(1));
    check("swap_ovf",   112'(n_ovf), 112'(o0 + 1));
    check("swap_rise",  112'(n_vrise), 112'(v0 + 1));
    check("stable",     112'(n_unstable), 112'(0));
    consume("ovf");

    // retrigger during bit 30 of a partial frame
    f1 = rand_frame(1);
    play(f1, 1, 10 * 76 - LEAD + 3, -1, 0, 0, 0);
    v0 = n_vrise; c0 = n_clr; p0 = n_perr;
    play(fb, 1, done_off(fb), -1, 1, 0, 0);
    idle(3);
    expect_frame("retrig", fb, v0);
    check("retrig_clr_n", 112'(n_clr), 112'(c0 + 1));
    check("retrig_err_n", 112'(n_perr), 112'(p0));
    consume("retrig");

    // random frames, ena duty and exact-tie halves
    for (int i = 0; i < 4; i++) begin
      f1 = rand_frame(2);
      v0 = n_vrise;
      play(f1, int'($urandom_range(1, 2)), done_off(f1), -1, 0, (i % 2) == 1, 0);
      idle(3);
      expect_frame("rand", f1, v0);
      consume("rand");
    end

    // half-rate ena, trigger raised on a non-ena clock
    v0 = n_vrise;
    play(fa, 2, done_off(fa), -1, 0, 0, 0);
    idle(3);
    expect_frame("half", fa, v0);
    check("half_lat", 112'(vrise_e - trig_e), 112'(2548));

    // asynchronous reset in the middle of DATA with a frame buffered
    c0 = n_clr;
    play(fb, 2, 600, -1, 0, 0, 0);
    @(negedge clk);
    check("mid_busy", 112'(busy), 112'(1));
    rst_n = 1'b0;
    #1;
    check("arst_busy",  112'(busy), 112'(0));
    check("arst_valid", 112'(frame_valid), 112'(0));
    check("arst_data",  frame_data, 112'(0));
    check("arst_long",  112'(frame_long), 112'(0));
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("arst_clr_n", 112'(n_clr), 112'(c0));
    check("arst_idle",  112'(busy), 112'(0));
    v0 = n_vrise;
    play(fa, 1, done_off(fa), -1, 0, 0, 0);
    idle(3);
    expect_frame("post_rst", fa, v0);
    consume("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
